register_file: RTL
==================

# register_file

Architectural register file for the single-cycle/pipelined MIPS datapath: 32 registers of 32 bits, two asynchronous read ports, and one synchronous write port. It sits directly downstream of the 5-bit destination-register multiplexer, whose output drives `write_reg`. Register 0 is hardwired to zero. An internal write-through bypass lets a read in the same cycle as a write to the same register see the new value.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width; `DEPTH = 2**ADDR_W` (32 entries)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `read_reg_1`  in  `ADDR_W`  port-1 read address (rs)
- `read_reg_2`  in  `ADDR_W`  port-2 read address (rt)
- `write_reg`  in  `ADDR_W`  write address, from the rt/rd destination mux
- `write_data`  in  `DATA_W`  write value
- `reg_write`  in  1  write enable
- `read_data_1`  out  `DATA_W`  port-1 read value
- `read_data_2`  out  `DATA_W`  port-2 read value

## Operation
- **Storage:** `DEPTH` x `DATA_W` flops. Entry 0 is never written and always reads 0.
- **Write:** on the rising `clk` edge with `rst_n`=1, `reg_write`=1 and `write_reg`!=0, the entry `write_reg` takes `write_data`.
  - `reg_write`=1 with `write_reg`=0 is a legal no-op.
  - X or Z on `write_reg` while `reg_write`=0 must not corrupt any entry.
- **Read (per port, purely combinational), in priority order:**
  1. `rst_n`=0 -> 0.
  2. address = 0 -> 0.
  3. `reg_write`=1 and `write_reg` equals the read address -> `write_data` (bypass).
  4. Otherwise -> stored entry.
- **Both ports read the same address:** identical values, including the bypass case.
- **Reset:** `rst_n` falling clears all 32 entries to 0 immediately, independent of `clk`.
  - While `rst_n`=0, writes are ignored and both outputs are 0.
  - Release of reset takes effect at the first rising edge with `rst_n`=1.
- **No stalls:** no handshake, no busy state. The block accepts a write every cycle.

## Timing
- **Read latency:** 0 cycles (combinational from address, `write_data` and `reg_write`).
- **Write latency:** 1 edge.
  - Value visible through the bypass in the same cycle.
  - Value visible from storage from the following cycle onward.
- **Reset values:** `read_data_1` = `read_data_2` = 0, all entries 0.
- **Reset asserted mid-cycle during a write:** the write is lost and the entry reads 0 after reset.
- **Back-to-back writes to the same register:** the last write wins; each is bypassed in its own cycle.
- **Critical path:** address compare plus 32:1 read mux plus 2:1 bypass mux. No registered outputs.

## Structure
- **Shared CPU package constants:** `DATA_W`, `ADDR_W`, `REG_ZERO` (5'd0), `REG_RA` (5'd31).
  - These are the same constants the destination mux and control unit use for the rt/rd/$ra selection.
- **Sub-module:** `reg_read_port` (address decode, bypass compare, zero-forcing).
  - Instantiated twice, so both ports are guaranteed identical behaviour.
- **Storage and write logic** live in the top-level `register_file`.

## Test plan
- **Reset:** hold `rst_n`=0 and drive `read_reg_1`=5, `read_reg_2`=31 -> both outputs 0.
  - Release reset, write 32'hDEAD_BEEF to r5 -> r5 reads 32'hDEAD_BEEF next cycle.
- **Zero register:** `reg_write`=1, `write_reg`=0, `write_data`=32'hFFFF_FFFF -> reading r0 returns 0 in the same cycle and all later cycles.
  - Scan r1..r31: no entry changed.
- **Bypass:** in one cycle write r7=32'h1234_5678 while `read_reg_1`=7 and `read_reg_2`=7 -> both outputs 32'h1234_5678 that cycle.
  - Then `reg_write`=0 -> both outputs still 32'h1234_5678 from storage.
- **Full sweep:** write r_i = i*32'h0101_0101 for i=1..31, then read all pairs (i, 32-i) -> exact values, with r0 = 0.
- **Enable low:** `reg_write`=0, `write_reg`=9, `write_data`=32'hAAAA_AAAA -> r9 keeps its previous value 32'h0909_0909.
  - No bypass: the output shows the stored value, not `write_data`.
- **Async reset mid-operation:** fill r1..r31, pulse `rst_n` low for 3 ns between edges -> all reads 0 immediately.
  - A write presented at the next edge with `rst_n` still low is dropped.
  - The first write after release succeeds.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared CPU constants used by the register file, destination mux and control unit.
package register_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: zero-forcing, write-through bypass, then storage lookup.
module reg_read_port #(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic                                   rst_n,
  input  logic [ADDR_W-1:0]                      read_reg,
  input  logic                                   reg_write,
  input  logic [ADDR_W-1:0]                      write_reg,
  input  logic [DATA_W-1:0]                      write_data,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]     regs,
  output logic [DATA_W-1:0]                      read_data
);
  import register_file_pkg::*;

  // Priority: reset, r0, same-cycle write to this address, stored value.
  always_comb begin
    read_data = '0;
    if (!rst_n) begin
      read_data = '0;
    end else if (read_reg == ADDR_W'(REG_ZERO)) begin
      read_data = '0;
    end else if (reg_write && (write_reg == read_reg)) begin
      read_data = write_data;
    end else begin
      read_data = regs[read_reg];
    end
  end

endmodule

// File: rtl/register_file.sv
// 32x32 MIPS architectural register file: two async read ports with bypass, one sync write port.
module register_file #(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);
  import register_file_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;

  // Per-entry address match keeps an X/Z write_reg from touching anything while reg_write=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (reg_write && (write_reg != ADDR_W'(REG_ZERO))) begin
      for (int i = 1; i < NREGS; i++) begin
        if (write_reg == ADDR_W'(i)) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_1 (
    .rst_n      (rst_n),
    .read_reg   (read_reg_1),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regs       (regs),
    .read_data  (read_data_1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_2 (
    .rst_n      (rst_n),
    .read_reg   (read_reg_2),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regs       (regs),
    .read_data  (read_data_2)
  );

endmodule
